// File: rtl/auto_turn_if.sv
// Command/status bundle between the motion controller and the auto-turn sequencer.
// master drives requests and enable/cancel; slave (the sequencer) drives steering and status.
interface auto_turn_if #(
    parameter int QUEUE_DEPTH = 4,
    parameter int CNT_W       = 16
);
    localparam int QCW = $clog2(QUEUE_DEPTH) + 1;

    logic             enable;
    logic             trigger_turn_left;
    logic             trigger_turn_right;
    logic             trigger_turn_back;
    logic             cancel;
    logic             turn_left;
    logic             turn_right;
    logic             is_turning;
    logic             busy;
    logic             done;
    logic             drop;
    logic [QCW-1:0]   queue_count;
    logic             queue_full;
    logic [CNT_W-1:0] remaining;

    modport master (
        output enable, trigger_turn_left, trigger_turn_right, trigger_turn_back, cancel,
        input  turn_left, turn_right, is_turning, busy, done, drop,
        input  queue_count, queue_full, remaining
    );

    modport slave (
        input  enable, trigger_turn_left, trigger_turn_right, trigger_turn_back, cancel,
        output turn_left, turn_right, is_turning, busy, done, drop,
        output queue_count, queue_full, remaining
    );
endinterface

// File: rtl/auto_turn_sequencer.sv
// Queued auto-turn sequencer: edge-detects turn requests, buffers them, and plays
// each turn for a fixed tick count followed by a straight settle gap.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | straight, waiting; pops the queue head when non-empty
//   ST_TURN   | steering; cnt_q counts down the remaining turn ticks
//   ST_SETTLE | straight gap after a turn; pops the next entry at its end
module auto_turn_sequencer #(
    parameter int TURN_TICKS   = 450,
    parameter int BACK_MULT    = 2,
    parameter int SETTLE_TICKS = 50,
    parameter int QUEUE_DEPTH  = 4,
    parameter int CNT_W        = 16
) (
    input logic       clk,
    input logic       rst,
    auto_turn_if.slave bus
);
    localparam int AW  = $clog2(QUEUE_DEPTH);
    localparam int QCW = AW + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_TURN   = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;

    localparam logic [1:0] CMD_L = 2'd0;
    localparam logic [1:0] CMD_R = 2'd1;
    localparam logic [1:0] CMD_B = 2'd2;

    localparam logic [CNT_W-1:0] LR_LOAD     = CNT_W'(TURN_TICKS - 1);
    localparam logic [CNT_W-1:0] B_LOAD      = CNT_W'(TURN_TICKS * BACK_MULT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_TICKS - 1);
    localparam logic [QCW-1:0]   Q_FULL      = QCW'(QUEUE_DEPTH);

    logic [1:0]       state_q, state_d;
    logic [1:0]       dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fifo_q [QUEUE_DEPTH];
    logic [1:0]       fifo_d [QUEUE_DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [QCW-1:0]   count_q, count_d;
    logic [2:0]       prev_q, prev_d;
    logic             done_q, done_d, drop_q, drop_d;
    logic             turn_left_q, turn_left_d, turn_right_q, turn_right_d;
    logic             is_turning_q, is_turning_d, busy_q, busy_d;
    logic             queue_full_q, queue_full_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;

    logic [2:0] trig, rise;
    logic       one_rise, multi_rise, pop, push;
    logic [1:0] cmd_new;

    assign trig       = {bus.trigger_turn_back, bus.trigger_turn_right, bus.trigger_turn_left};
    assign rise       = trig & ~prev_q;
    assign multi_rise = (rise[0] & rise[1]) | (rise[0] & rise[2]) | (rise[1] & rise[2]);
    assign one_rise   = (|rise) & ~multi_rise;

    always_comb begin
        cmd_new = CMD_L;
        if (rise[1]) cmd_new = CMD_R;
        if (rise[2]) cmd_new = CMD_B;
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        fifo_d  = fifo_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        done_d  = 1'b0;
        drop_d  = 1'b0;
        pop     = 1'b0;
        push    = 1'b0;
        prev_d  = trig;
        if (!bus.enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: pop = (count_q != '0);
                ST_TURN: begin
                    if (bus.cancel) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == '0) begin
                        done_d = 1'b1;
                        if (SETTLE_TICKS == 0) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_SETTLE;
                            cnt_d   = SETTLE_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (bus.cancel) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == '0) begin
                        // chain straight into the next turn so the gap is exactly SETTLE_TICKS
                        if (count_q != '0) pop = 1'b1;
                        else state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase

            if (pop) begin
                dir_d   = fifo_q[rd_q];
                state_d = ST_TURN;
                cnt_d   = (fifo_q[rd_q] == CMD_B) ? B_LOAD : LR_LOAD;
                rd_d    = rd_q + AW'(1);
            end

            // a pop on the same edge frees a slot for an incoming request
            if (one_rise) begin
                if (count_q != Q_FULL || pop) push = 1'b1;
                else drop_d = 1'b1;
            end else if (multi_rise) begin
                drop_d = 1'b1;
            end

            if (push) begin
                fifo_d[wr_q] = cmd_new;
                wr_d         = wr_q + AW'(1);
            end
            count_d = count_q + QCW'(push) - QCW'(pop);
        end
    end

    always_comb begin
        is_turning_d = (state_d == ST_TURN);
        turn_left_d  = is_turning_d && (dir_d == CMD_L);
        turn_right_d = is_turning_d && (dir_d != CMD_L);
        busy_d       = (state_d != ST_IDLE);
        remaining_d  = is_turning_d ? cnt_d + CNT_W'(1) : '0;
        queue_full_d = (count_d == Q_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            dir_q        <= CMD_L;
            cnt_q        <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) fifo_q[i] <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            count_q      <= '0;
            prev_q       <= '0;
            done_q       <= 1'b0;
            drop_q       <= 1'b0;
            turn_left_q  <= 1'b0;
            turn_right_q <= 1'b0;
            is_turning_q <= 1'b0;
            busy_q       <= 1'b0;
            queue_full_q <= 1'b0;
            remaining_q  <= '0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            cnt_q        <= cnt_d;
            fifo_q       <= fifo_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            count_q      <= count_d;
            prev_q       <= prev_d;
            done_q       <= done_d;
            drop_q       <= drop_d;
            turn_left_q  <= turn_left_d;
            turn_right_q <= turn_right_d;
            is_turning_q <= is_turning_d;
            busy_q       <= busy_d;
            queue_full_q <= queue_full_d;
            remaining_q  <= remaining_d;
        end
    end

    assign bus.turn_left   = turn_left_q;
    assign bus.turn_right  = turn_right_q;
    assign bus.is_turning  = is_turning_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.drop        = drop_q;
    assign bus.queue_count = count_q;
    assign bus.queue_full  = queue_full_q;
    assign bus.remaining   = remaining_q;
endmodule

// File: tb/tb_auto_turn_sequencer.sv
// Bench for auto_turn_sequencer: a queue-based reference model predicts every output cycle;
// a monitor compares the DUT against the predictions, plus scenario-level tallies.
module tb_auto_turn_sequencer;
    localparam int TT  = 4;
    localparam int BM  = 2;
    localparam int ST  = 2;
    localparam int QD  = 2;
    localparam int CW  = 16;
    localparam int QCW = 2;

    logic clk = 1'b0;
    logic rst;

    auto_turn_if #(.QUEUE_DEPTH(QD), .CNT_W(CW)) bus_if ();

    auto_turn_sequencer #(
        .TURN_TICKS(TT), .BACK_MULT(BM), .SETTLE_TICKS(ST), .QUEUE_DEPTH(QD), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic           tl;
        logic           tr;
        logic           it;
        logic           busy;
        logic           done;
        logic           drop;
        logic [QCW-1:0] qc;
        logic           qf;
        logic [CW-1:0]  rem;
    } obs_t;

    obs_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   n_turn = 0, n_done = 0, n_drop = 0, n_qmax = 0;

    // Reference model: pending commands (0=L,1=R,2=B), ticks left in the turn, straight ticks left.
    int       m_q[$];
    int       m_turn = 0;
    int       m_settle = 0;
    int       m_dir = 0;
    bit [2:0] m_prev = 3'b000;

    function automatic obs_t model_step(input bit r, input bit en, input bit l,
                                        input bit rt, input bit b, input bit c);
        bit [2:0] trg;
        bit [2:0] rs;
        int       nr;
        bit       dn;
        bit       dp;
        bit       take;
        obs_t     o;
        trg    = {b, rt, l};
        rs     = trg & ~m_prev;
        m_prev = trg;
        nr     = int'(rs[0]) + int'(rs[1]) + int'(rs[2]);
        dn     = 1'b0;
        dp     = 1'b0;
        take   = 1'b0;
        if (r) begin
            m_q.delete();
            m_turn   = 0;
            m_settle = 0;
            m_dir    = 0;
            m_prev   = 3'b000;
        end else if (!en) begin
            m_q.delete();
            m_turn   = 0;
            m_settle = 0;
        end else begin
            if (c && (m_turn > 0 || m_settle > 0)) begin
                m_turn   = 0;
                m_settle = 0;
            end else if (m_turn > 0) begin
                m_turn--;
                if (m_turn == 0) begin
                    dn       = 1'b1;
                    m_settle = ST;
                end
            end else if (m_settle > 0) begin
                m_settle--;
                take = (m_settle == 0);
            end else begin
                take = 1'b1;
            end
            if (take && m_q.size() > 0) begin
                m_dir  = m_q.pop_front();
                m_turn = (m_dir == 2) ? TT * BM : TT;
            end
            if (nr > 1) dp = 1'b1;
            else if (nr == 1) begin
                if (m_q.size() < QD) m_q.push_back(rs[0] ? 0 : (rs[1] ? 1 : 2));
                else dp = 1'b1;
            end
        end
        o.tl   = (m_turn > 0) && (m_dir == 0);
        o.tr   = (m_turn > 0) && (m_dir != 0);
        o.it   = (m_turn > 0);
        o.busy = (m_turn > 0) || (m_settle > 0);
        o.done = dn;
        o.drop = dp;
        o.qc   = QCW'(m_q.size());
        o.qf   = (m_q.size() == QD);
        o.rem  = CW'(m_turn);
        return o;
    endfunction

    task automatic cyc(input bit r, input bit en, input bit l, input bit rt,
                       input bit b, input bit c);
        @(negedge clk);
        rst                       = r;
        bus_if.enable             = en;
        bus_if.trigger_turn_left  = l;
        bus_if.trigger_turn_right = rt;
        bus_if.trigger_turn_back  = b;
        bus_if.cancel             = c;
        exp_q.push_back(model_step(r, en, l, rt, b, c));
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic begin_scn();
        n_turn = 0;
        n_done = 0;
        n_drop = 0;
        n_qmax = 0;
    endtask

    task automatic end_scn();
        @(posedge clk);
        #2;
    endtask

    task automatic check_val(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s got=%0d expected=%0d", name, act, expv);
        end
    endtask

    // Monitor: one registered output vector per clock, compared against the oldest prediction.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                obs_t e;
                obs_t a;
                e = exp_q.pop_front();
                a = {bus_if.turn_left, bus_if.turn_right, bus_if.is_turning, bus_if.busy,
                     bus_if.done, bus_if.drop, bus_if.queue_count, bus_if.queue_full,
                     bus_if.remaining};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t got=%h expected=%h", $time, a, e);
                end
                n_turn += int'(a.it);
                n_done += int'(a.done);
                n_drop += int'(a.drop);
                if (int'(a.qc) > n_qmax) n_qmax = int'(a.qc);
            end
        end
    end

    initial begin
        bit tl, tr, tb;
        rst                       = 1'b1;
        bus_if.enable             = 1'b0;
        bus_if.trigger_turn_left  = 1'b0;
        bus_if.trigger_turn_right = 1'b0;
        bus_if.trigger_turn_back  = 1'b0;
        bus_if.cancel             = 1'b0;

        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        end_scn();

        // single left pulse
        begin_scn();
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(11);
        end_scn();
        check_val("left_turn_cycles", n_turn, TT);
        check_val("left_done", n_done, 1);

        // single back pulse
        begin_scn();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(15);
        end_scn();
        check_val("back_turn_cycles", n_turn, TT * BM);
        check_val("back_done", n_done, 1);

        // L, R, B back-to-back
        begin_scn();
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(24);
        end_scn();
        check_val("lrb_turn_cycles", n_turn, 16);
        check_val("lrb_done", n_done, 3);
        check_val("lrb_drop", n_drop, 0);
        check_val("lrb_queue_peak", n_qmax, 2);

        // simultaneous rises
        begin_scn();
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(5);
        end_scn();
        check_val("multi_drop", n_drop, 1);
        check_val("multi_turn_cycles", n_turn, 0);
        check_val("multi_queue_peak", n_qmax, 0);

        // held trigger fires once
        begin_scn();
        repeat (10) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(10);
        end_scn();
        check_val("held_turn_cycles", n_turn, TT);
        check_val("held_done", n_done, 1);

        // cancel in 2nd turn cycle with R queued
        begin_scn();
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(12);
        end_scn();
        check_val("cancel_turn_cycles", n_turn, 2 + TT);
        check_val("cancel_done", n_done, 1);

        // enable drop mid-turn with 2 queued, back held across re-enable
        begin_scn();
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end_scn();
        check_val("disable_done", n_done, 0);
        begin_scn();
        repeat (5) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(5);
        end_scn();
        check_val("reenable_turn_cycles", n_turn, 0);
        check_val("reenable_queue_peak", n_qmax, 0);

        // reset mid-turn
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end_scn();
        begin_scn();
        idle(8);
        end_scn();
        check_val("post_reset_turn_cycles", n_turn, 0);

        // randomized traffic
        tl = 1'b0;
        tr = 1'b0;
        tb = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            bit c, en, r;
            if ($urandom_range(5) == 0) tl = ~tl;
            if ($urandom_range(5) == 0) tr = ~tr;
            if ($urandom_range(7) == 0) tb = ~tb;
            c  = ($urandom_range(24) == 0);
            en = ($urandom_range(59) != 0);
            r  = ($urandom_range(299) == 0);
            cyc(r, en, tl, tr, tb, c);
        end
        idle(4);
        end_scn();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
